// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Brief    : VGA raster timing: pixel enable, coordinates, syncs, video-on,
//             line/frame strobes and a frame-locked blink signal.
//  Revision : 1.0
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pixel_tick,
    output logic [9:0] o_pixel_x,
    output logic [9:0] o_pixel_y,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_video_on,
    output logic       o_line_tick,
    output logic       o_frame_tick,
    output logic       o_blink
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_FC_W-1:0]  c_FC_MAX   = c_FC_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]         c_H_MAX    = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]         c_V_MAX    = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]         c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]         c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]         c_HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]         c_HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0]         c_VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]         c_VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [c_DIV_W-1:0] r_div;
    logic [c_FC_W-1:0]  r_frame_cnt;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_pixel_tick;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_line_tick;
    logic               r_frame_tick;
    logic               r_blink;

    logic [c_DIV_W-1:0] w_div_next;
    logic [c_FC_W-1:0]  w_frame_cnt_next;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;
    logic               w_tick;
    logic               w_line;
    logic               w_frame;
    logic               w_blink_next;
    logic               w_hs_active;
    logic               w_vs_active;
    logic               w_video_on;

    always_comb begin
        w_tick           = (r_div == c_DIV_MAX);
        w_div_next       = w_tick ? '0 : r_div + 1'b1;
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_line           = w_tick && (r_x == c_H_MAX);
        w_frame          = w_line && (r_y == c_V_MAX);
        w_frame_cnt_next = r_frame_cnt;
        w_blink_next     = r_blink;

        if (w_tick) begin
            if (r_x == c_H_MAX) begin
                w_x_next = '0;
                w_y_next = (r_y == c_V_MAX) ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end

        // The counter clears on the frame that would reach BLINK_FRAMES.
        if (w_frame) begin
            if (r_frame_cnt == c_FC_MAX) begin
                w_frame_cnt_next = '0;
                w_blink_next     = ~r_blink;
            end else begin
                w_frame_cnt_next = r_frame_cnt + 1'b1;
            end
        end

        // Decoded from next-state counters so they line up with pixel_x/y.
        w_hs_active = (w_x_next >= c_HS_FIRST) && (w_x_next <= c_HS_LAST);
        w_vs_active = (w_y_next >= c_VS_FIRST) && (w_y_next <= c_VS_LAST);
        w_video_on  = (w_x_next < c_H_VIS) && (w_y_next < c_V_VIS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div        <= '0;
            r_pixel_tick <= 1'b0;
            r_x          <= c_H_MAX;
            r_y          <= c_V_MAX;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video_on   <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
            r_blink      <= 1'b0;
        end else begin
            r_div        <= w_div_next;
            r_pixel_tick <= w_tick;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_hsync      <= w_hs_active ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_vs_active ? SYNC_POL : ~SYNC_POL;
            r_video_on   <= w_video_on;
            r_line_tick  <= w_line;
            r_frame_tick <= w_frame;
            r_frame_cnt  <= w_frame_cnt_next;
            r_blink      <= w_blink_next;
        end
    end

    assign o_pixel_tick = r_pixel_tick;
    assign o_pixel_x    = r_x;
    assign o_pixel_y    = r_y;
    assign o_hsync      = r_hsync;
    assign o_vsync      = r_vsync;
    assign o_video_on   = r_video_on;
    assign o_line_tick  = r_line_tick;
    assign o_frame_tick = r_frame_tick;
    assign o_blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Brief    : Bench for vga_sync_gen: three configurations against a
//             raster-position arithmetic model, with random reset points.
//  Revision : 1.0
// ============================================================================
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    logic       t0, hs0, vs0, vo0, lt0, ft0, bl0;
    logic [9:0] x0, y0;
    logic       t1, hs1, vs1, vo1, lt1, ft1, bl1;
    logic [9:0] x1, y1;
    logic       t2, hs2, vs2, vo2, lt2, ft2, bl2;
    logic [9:0] x2, y2;

    vga_sync_gen u0 (
        .clk(clk), .rst(rst), .o_pixel_tick(t0), .o_pixel_x(x0), .o_pixel_y(y0),
        .o_hsync(hs0), .o_vsync(vs0), .o_video_on(vo0), .o_line_tick(lt0),
        .o_frame_tick(ft0), .o_blink(bl0)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1),
        .BLINK_FRAMES(30)
    ) u1 (
        .clk(clk), .rst(rst), .o_pixel_tick(t1), .o_pixel_x(x1), .o_pixel_y(y1),
        .o_hsync(hs1), .o_vsync(vs1), .o_video_on(vo1), .o_line_tick(lt1),
        .o_frame_tick(ft1), .o_blink(bl1)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_VISIBLE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0),
        .BLINK_FRAMES(2)
    ) u2 (
        .clk(clk), .rst(rst), .o_pixel_tick(t2), .o_pixel_x(x2), .o_pixel_y(y2),
        .o_hsync(hs2), .o_vsync(vs2), .o_video_on(vo2), .o_line_tick(lt2),
        .o_frame_tick(ft2), .o_blink(bl2)
    );

    // Expected outputs after n clk edges since reset release, derived from
    // the number of pixel ticks and the linear raster position.
    function automatic logic [26:0] model(input int cyc, input int div,
                                          input int hv, input int hfp, input int hsw, input int hbp,
                                          input int vv, input int vfp, input int vsw, input int vbp,
                                          input bit pol, input int bf);
        int  ht, vt, area, ticks, p, x, y, frames;
        bit  tick_now, hs, vs, von, lt, ft, bl;
        ht       = hv + hfp + hsw + hbp;
        vt       = vv + vfp + vsw + vbp;
        area     = ht * vt;
        ticks    = cyc / div;
        tick_now = (cyc > 0) && (cyc % div == 0);
        if (ticks == 0) begin
            x = ht - 1;
            y = vt - 1;
            frames = 0;
        end else begin
            p = (ticks - 1) % area;
            x = p % ht;
            y = p / ht;
            frames = (ticks - 1) / area + 1;
        end
        hs  = (x >= hv + hfp && x < hv + hfp + hsw) ? pol : ~pol;
        vs  = (y >= vv + vfp && y < vv + vfp + vsw) ? pol : ~pol;
        von = (x < hv) && (y < vv);
        lt  = tick_now && (x == 0);
        ft  = lt && (y == 0);
        bl  = ((frames / bf) % 2) == 1;
        return {tick_now, 10'(x), 10'(y), hs, vs, von, lt, ft, bl};
    endfunction

    task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        check("u0_default", {t0, x0, y0, hs0, vs0, vo0, lt0, ft0, bl0},
              model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 30));
        check("u1_div1_pos", {t1, x1, y1, hs1, vs1, vo1, lt1, ft1, bl1},
              model(n, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 30));
        check("u2_div3", {t2, x2, y2, hs2, vs2, vo2, lt2, ft2, bl2},
              model(n, 3, 5, 1, 2, 1, 3, 1, 1, 2, 1'b0, 2));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n++;
            check_all();
            if (n == 4)
                check("u0_first_tick", {t0, x0, y0, hs0, vs0, vo0, lt0, ft0, bl0},
                      {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        end
    endtask

    // Reset is asserted between clock edges so only an asynchronous clear
    // can produce the reset values at the first check.
    task automatic do_reset(input int hold);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 n = 0;
        check_all();
        check("u0_reset", {t0, x0, y0, hs0, vs0, vo0, lt0, ft0, bl0},
              {1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
        check_all();
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n = 0;
        check_all();
        check("u0_reset", {t0, x0, y0, hs0, vs0, vo0, lt0, ft0, bl0},
              {1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        run(6000 + int'($urandom_range(0, 400)));
        do_reset(int'($urandom_range(1, 4)));
        run(6200);
        do_reset(int'($urandom_range(1, 4)));
        run(int'($urandom_range(500, 2500)));
        do_reset(1);
        run(3300);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
